// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Multi-cycle control sequencer for the 32-bit RISC-like datapath. It accepts
//   one instruction per valid/ready handshake and steps it through
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB], driving the datapath strobes.
//   An unknown opcode parks the sequencer in TRAP with a sticky illegal flag
//   until reset.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start                    leave IDLE and begin sequencing
//   instr[31:0], instr_valid instruction word (opcode = instr[31:26]) and valid
//   instr_ready              sequencer accepts instr this cycle (FETCH)
//   zero_flag                datapath zero flag, steers bz
//   mem_ready                data memory done (only with MEM_WAIT_EN)
//   ir_we, rf_re             IR latch, register-file read
//   alu_op[2:0], alu_src_imm ALU op (0 ADD, 1 AND, 2 PASS_A), immediate B operand
//   reg_dst, wb_sel          write destination (1 = rd), write-back source (1 = mem)
//   mem_re, mem_we           data-memory read / write
//   rf_we, sp_we             register-file / stack-pointer write
//   pc_we, pc_sel_branch     PC update, branch-target select
//   retired                  one-cycle pulse in the last cycle of an instruction
//   illegal                  sticky unknown-opcode flag
//   state[2:0]               current state, for debug
//
// Configuration
//   MEM_WAIT_EN  when defined, MEM holds its strobe until mem_ready is sampled high;
//                otherwise MEM lasts exactly one cycle and mem_ready is ignored.

module ctrl_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        rf_re,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_dst,
    output logic        wb_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        rf_we,
    output logic        sp_we,
    output logic        pc_we,
    output logic        pc_sel_branch,
    output logic        retired,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_AND  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_LD   = 6'b001101;
    localparam logic [5:0] OP_ST   = 6'b001110;
    localparam logic [5:0] OP_LDSP = 6'b001111;
    localparam logic [5:0] OP_MOVE = 6'b010001;
    localparam logic [5:0] OP_BZ   = 6'b010101;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_PASS = 3'd2;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;
    logic       r_illegal;

    // Opcode class flags
    logic       w_legal, w_load, w_store, w_branch, w_imm, w_rd, w_sp;
    logic [2:0] w_alu_sel;
    logic       w_mem_done;
    logic       w_unused;

    // Ungated strobes; the ports force them low while rst is high
    logic       w_instr_ready, w_ir_we, w_rf_re, w_alu_src_imm, w_reg_dst, w_wb_sel;
    logic       w_mem_re, w_mem_we, w_rf_we, w_sp_we, w_pc_we, w_pc_sel, w_retired;
    logic [2:0] w_alu_op;

`ifdef MEM_WAIT_EN
    assign w_mem_done = mem_ready;
    assign w_unused   = ^instr[25:0];
`else
    assign w_mem_done = 1'b1;
    assign w_unused   = ^{instr[25:0], mem_ready};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_opcode  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && instr_valid)
                r_opcode <= instr[31:26];
            if (r_state == S_DECODE && !w_legal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_legal   = 1'b1;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_branch  = 1'b0;
        w_imm     = 1'b0;
        w_rd      = 1'b0;
        w_sp      = 1'b0;
        w_alu_sel = ALU_ADD;
        case (r_opcode)
            OP_ADD:  w_rd = 1'b1;
            OP_AND:  begin w_alu_sel = ALU_AND; w_rd = 1'b1; end
            OP_ADDI: w_imm = 1'b1;
            OP_LD:   begin w_load = 1'b1; w_imm = 1'b1; end
            OP_ST:   begin w_store = 1'b1; w_imm = 1'b1; end
            OP_LDSP: begin w_load = 1'b1; w_imm = 1'b1; w_sp = 1'b1; end
            OP_MOVE: begin w_alu_sel = ALU_PASS; w_rd = 1'b1; end
            OP_BZ:   begin w_alu_sel = ALU_PASS; w_branch = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_instr_ready = 1'b0;
        w_ir_we       = 1'b0;
        w_rf_re       = 1'b0;
        w_alu_op      = '0;
        w_alu_src_imm = 1'b0;
        w_reg_dst     = 1'b0;
        w_wb_sel      = 1'b0;
        w_mem_re      = 1'b0;
        w_mem_we      = 1'b0;
        w_rf_we       = 1'b0;
        w_sp_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_sel      = 1'b0;
        w_retired     = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_FETCH;
            S_FETCH: begin
                w_instr_ready = 1'b1;
                if (instr_valid) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                w_rf_re = 1'b1;
                w_next  = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                w_alu_op      = w_alu_sel;
                w_alu_src_imm = w_imm;
                if (w_branch) begin
                    // bz completes here; the PC select tracks zero_flag live
                    w_pc_we   = 1'b1;
                    w_pc_sel  = zero_flag;
                    w_retired = 1'b1;
                    w_next    = S_FETCH;
                end else if (w_load || w_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_re = w_load;
                w_mem_we = w_store;
                if (w_mem_done) begin
                    if (w_store) begin
                        w_pc_we   = 1'b1;
                        w_retired = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_pc_we   = 1'b1;
                w_retired = 1'b1;
                w_rf_we   = !w_sp;
                w_sp_we   = w_sp;
                w_wb_sel  = w_load;
                w_reg_dst = w_rd;
                w_next    = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    // A reset cycle silences every output so an aborted instruction never
    // writes into the datapath.
    assign instr_ready   = w_instr_ready & ~rst;
    assign ir_we         = w_ir_we & ~rst;
    assign rf_re         = w_rf_re & ~rst;
    assign alu_op        = rst ? '0 : w_alu_op;
    assign alu_src_imm   = w_alu_src_imm & ~rst;
    assign reg_dst       = w_reg_dst & ~rst;
    assign wb_sel        = w_wb_sel & ~rst;
    assign mem_re        = w_mem_re & ~rst;
    assign mem_we        = w_mem_we & ~rst;
    assign rf_we         = w_rf_we & ~rst;
    assign sp_we         = w_sp_we & ~rst;
    assign pc_we         = w_pc_we & ~rst;
    assign pc_sel_branch = w_pc_sel & ~rst;
    assign retired       = w_retired & ~rst;
    assign illegal       = r_illegal & ~rst;
    assign state         = rst ? '0 : r_state;

endmodule
